scroll_controller: RTL and testbench



---
 rtl/scroll_pkg.sv | 25 ++
 rtl/scroll_controller_if.sv | 26 ++
 rtl/scroll_controller_frame_edge_detect.sv | 24 ++
 rtl/scroll_controller.sv | 102 ++++++++++
 tb/tb_scroll_controller.sv | 136 +++++++++++++
 5 files changed

// File: rtl/scroll_pkg.sv
// -----------------------------------------------------------------------------
// scroll_pkg
// Shared types and constants for the camera/scroll stage.
//   scroll_state_t : FOLLOW (player moves), SCROLL (camera absorbs motion),
//                    END (clamped at level end).
//   SCROLL_THRESH  : player X at/after which rightward motion scrolls.
//   MAX_PROCESS    : largest scroll offset; keeps process + DrawX in 10 bits.
//   BACK_THRESH    : player X at/below which leftward motion scrolls back
//                    (only used when SCROLL_BACK_EN is defined).
// -----------------------------------------------------------------------------
package scroll_pkg;
  typedef enum logic [1:0] {
    FOLLOW = 2'd0,
    SCROLL = 2'd1,
    END    = 2'd2
  } scroll_state_t;

  localparam int SCREEN_W = 640;
  localparam int SCROLL_W = 10;
  localparam int STEP_W   = 4;

  localparam logic [SCROLL_W-1:0] SCROLL_THRESH = 10'd320;
  localparam logic [SCROLL_W-1:0] MAX_PROCESS   = 10'd384;
  localparam logic [SCROLL_W-1:0] BACK_THRESH   = 10'd160;
endpackage

// File: rtl/scroll_controller_if.sv
// -----------------------------------------------------------------------------
// scroll_controller_if
// Player-side bundle of the scroll stage.
//   ball_x      : player screen X (unsigned)
//   step        : player horizontal speed this frame, 0..15
//   dir         : 0 = right, 1 = left
//   freeze      : pause/death, blocks all updates
//   process     : world scroll offset
//   hold_player : player X must not advance this frame
//   at_end      : scroll clamped at MAX_PROCESS
// master = player/test side, slave = scroll_controller.
// -----------------------------------------------------------------------------
interface scroll_controller_if;
  logic [scroll_pkg::SCROLL_W-1:0] ball_x;
  logic [scroll_pkg::STEP_W-1:0]   step;
  logic                            dir;
  logic                            freeze;
  logic [scroll_pkg::SCROLL_W-1:0] process;
  logic                            hold_player;
  logic                            at_end;

  modport master (output ball_x, step, dir, freeze,
                  input  process, hold_player, at_end);
  modport slave  (input  ball_x, step, dir, freeze,
                  output process, hold_player, at_end);
endinterface

// File: rtl/scroll_controller_frame_edge_detect.sv
// -----------------------------------------------------------------------------
// frame_edge_detect
// Turns the vsync-derived frame strobe into a one-Clk-cycle tick on its
// rising edge, so a strobe held high for many cycles counts once.
//   Clk        : system clock
//   Reset      : synchronous, active-high
//   frame_clk  : frame strobe, sampled in the Clk domain
//   frame_tick : frame_clk & ~frame_clk registered
// -----------------------------------------------------------------------------
module frame_edge_detect (
  input  logic Clk,
  input  logic Reset,
  input  logic frame_clk,
  output logic frame_tick
);
  logic r_frame_clk_q;

  always_ff @(posedge Clk) begin
    if (Reset) r_frame_clk_q <= 1'b0;
    else       r_frame_clk_q <= frame_clk;
  end

  assign frame_tick = frame_clk & ~r_frame_clk_q;
endmodule

// File: rtl/scroll_controller.sv
// -----------------------------------------------------------------------------
// scroll_controller
// Camera stage: produces the world scroll offset `process` added to DrawX by
// the downstream hit-test blocks. Advances once per frame while the player
// pushes right past SCROLL_THRESH, clamps at MAX_PROCESS (castle on screen).
// Ports:
//   Clk, Reset : clock, synchronous active-high reset
//   frame_clk  : frame strobe (edge-detected internally)
//   sbus       : scroll_controller_if.slave (player inputs, scroll outputs)
// Optional build macro SCROLL_BACK_EN: leftward motion at/below BACK_THRESH
// scrolls the world back (floored at 0) and releases END.
// -----------------------------------------------------------------------------
module scroll_controller
  import scroll_pkg::*;
(
  input  logic                Clk,
  input  logic                Reset,
  input  logic                frame_clk,
  scroll_controller_if.slave  sbus
);
  logic                 w_tick;
  logic                 w_past;
  logic                 w_fwd;
  logic [SCROLL_W:0]    w_sum;
  scroll_state_t        r_state, w_state_nxt;
  logic [SCROLL_W-1:0]  r_process, w_process_nxt;
  logic                 r_at_end;

  frame_edge_detect u_edge (
    .Clk        (Clk),
    .Reset      (Reset),
    .frame_clk  (frame_clk),
    .frame_tick (w_tick)
  );

  assign w_past = (sbus.ball_x >= SCROLL_THRESH);
  assign w_fwd  = ~sbus.dir & (sbus.step != '0) & w_past;
  // 11-bit sum so the clamp compare can never see a wrapped value
  assign w_sum  = {1'b0, r_process} + {{(SCROLL_W+1-STEP_W){1'b0}}, sbus.step};

`ifdef SCROLL_BACK_EN
  logic                 w_back;
  logic                 w_floor;
  assign w_back  = sbus.dir & (sbus.step != '0) & (sbus.ball_x <= BACK_THRESH);
  assign w_floor = ({1'b0, r_process} < {{(SCROLL_W+1-STEP_W){1'b0}}, sbus.step});
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state   <= FOLLOW;
      r_process <= '0;
      r_at_end  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_process <= w_process_nxt;
      r_at_end  <= (w_state_nxt == END);
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_process_nxt = r_process;
    if (w_tick && !sbus.freeze) begin
`ifdef SCROLL_BACK_EN
      if (w_back) begin
        w_process_nxt = w_floor ? '0
                      : r_process - {{(SCROLL_W-STEP_W){1'b0}}, sbus.step};
        // leaving the clamp re-arms scrolling; otherwise dir=1 means FOLLOW
        w_state_nxt   = (r_state == END) ? SCROLL : FOLLOW;
      end else
`endif
      case (r_state)
        // FOLLOW and SCROLL react identically: forward push applies the
        // increment in the same tick, anything else drops back to FOLLOW.
        FOLLOW, SCROLL: begin
          if (w_fwd) begin
            if (w_sum >= {1'b0, MAX_PROCESS}) begin
              w_process_nxt = MAX_PROCESS;
              w_state_nxt   = END;
            end else begin
              w_process_nxt = w_sum[SCROLL_W-1:0];
              w_state_nxt   = SCROLL;
            end
          end else begin
            w_state_nxt = FOLLOW;
          end
        end
        END:     w_state_nxt = END;
        default: w_state_nxt = FOLLOW;
      endcase
    end
  end

  assign sbus.process = r_process;
  assign sbus.at_end  = r_at_end;
`ifdef SCROLL_BACK_EN
  assign sbus.hold_player = ~sbus.freeze &
                            (((r_state != END) & ~sbus.dir & w_past) | w_back);
`else
  assign sbus.hold_player = ~sbus.freeze & (r_state != END) & ~sbus.dir & w_past;
`endif
endmodule

// File: tb/tb_scroll_controller.sv
module tb_scroll_controller;
  import scroll_pkg::*;

`ifdef SCROLL_BACK_EN
  localparam bit BACK = 1'b1;
`else
  localparam bit BACK = 1'b0;
`endif

  typedef struct {
    logic       rst;
    logic [9:0] bx;
    logic [3:0] st;
    logic       dir;
    logic       frz;
    int         hi;      // Clk cycles frame_clk stays high
    logic [9:0] e_proc;
    logic       e_end;
    logic       e_hold;  // checked right after inputs are applied
  } vec_t;

  typedef struct {
    logic [9:0] e_proc;
    logic       e_end;
  } exp_t;

  logic Clk = 1'b0;
  logic Reset;
  logic frame_clk;
  always #5 Clk = ~Clk;

  scroll_controller_if sif();

  scroll_controller dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .frame_clk (frame_clk),
    .sbus      (sif)
  );

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void add(input logic rst, input logic [9:0] bx, input logic [3:0] st,
                              input logic dir, input logic frz, input int hi,
                              input logic [9:0] e_proc, input logic e_end, input logic e_hold);
    vecs.push_back('{rst, bx, st, dir, frz, hi, e_proc, e_end, e_hold});
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    exp_t e;
    // idle player left of threshold: nothing moves
    for (int k = 0; k < 5; k++) add(0, 100, 4, 0, 0, 1, 0, 0, 0);
    // at threshold: 5, 10, 15; last tick has frame_clk high for 20 cycles
    add(0, 320, 5, 0, 0, 1, 5, 0, 1);
    add(0, 320, 5, 0, 0, 1, 10, 0, 1);
    add(0, 320, 5, 0, 0, 20, 15, 0, 1);
    for (int k = 1; k <= 24; k++) add(0, 320, 15, 0, 0, 1, 10'(15 + 15*k), 0, 1);
    add(0, 320, 5, 0, 0, 1, 380, 0, 1);
    // 380 + 7 overshoots: clamp to 384
    add(0, 320, 7, 0, 0, 1, 384, 1, 1);
    add(0, 320, 7, 0, 0, 1, 384, 1, 0);
    add(0, 320, 7, 0, 0, 1, 384, 1, 0);
    // leftward from END
    add(0, 100, 4, 1, 0, 1, BACK ? 10'd380 : 10'd384, !BACK, BACK);
    // reset with a tick present
    add(1, 320, 5, 0, 0, 1, 0, 0, 0);
    // exact hit of MAX: 32 * 12 = 384
    for (int k = 1; k <= 32; k++) add(0, 320, 12, 0, 0, 1, 10'(12*k), k == 32, 1);
    add(0, 320, 12, 0, 0, 1, 384, 1, 0);
    add(1, 320, 5, 0, 0, 1, 0, 0, 0);
    // climb to 200, then freeze
    for (int k = 1; k <= 13; k++) add(0, 320, 15, 0, 0, 1, 10'(15*k), 0, 1);
    add(0, 320, 5, 0, 0, 1, 200, 0, 1);
    for (int k = 0; k < 4; k++) add(0, 320, 5, 0, 1, 1, 200, 0, 0);
    // step=0 never changes process
    add(0, 320, 0, 0, 0, 1, 200, 0, 1);
    add(1, 320, 5, 0, 0, 1, 0, 0, 0);
    // floor on back-scroll: 3 - 6 -> 0
    add(0, 320, 3, 0, 0, 1, 3, 0, 1);
    add(0, 150, 6, 1, 0, 1, BACK ? 10'd0 : 10'd3, 0, BACK);

    // reset state
    Reset = 1'b1; frame_clk = 1'b0;
    sif.ball_x = '0; sif.step = '0; sif.dir = 1'b0; sif.freeze = 1'b0;
    repeat (3) @(negedge Clk);
    chk("reset_process", sif.process, 0);
    chk("reset_at_end", sif.at_end, 0);
    chk("reset_hold", sif.hold_player, 0);
    Reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge Clk);
      sif.ball_x = vecs[i].bx;
      sif.step   = vecs[i].st;
      sif.dir    = vecs[i].dir;
      sif.freeze = vecs[i].frz;
      Reset      = vecs[i].rst;
      frame_clk  = 1'b1;
      sb.push_back('{vecs[i].e_proc, vecs[i].e_end});
      #1;
      if (!vecs[i].rst) chk($sformatf("hold[%0d]", i), sif.hold_player, vecs[i].e_hold);
      repeat (vecs[i].hi) @(negedge Clk);
      frame_clk = 1'b0;
      Reset     = 1'b0;
      @(negedge Clk);
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL scoreboard[%0d]: got empty queue expected an entry", i);
      end else begin
        e = sb.pop_front();
        chk($sformatf("process[%0d]", i), sif.process, e.e_proc);
        chk($sformatf("at_end[%0d]", i), sif.at_end, e.e_end);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
